msrv32_pc_pipe_reg: RTL and testbench
=====================================

MSRV32_PC_PIPE_REG -- requirements
Module: msrv32_pc_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, PC width in bits; legal values are 32 and 64.
REQ-002 Parameter BOOT_ADDRESS, default 32'h0000_0000, PC value after reset; bits [1:0] are zero.
REQ-003 Parameter DEPTH, default 3, number of PC tracking stages; legal range 1..8.
REQ-004 Port clk_in, input, 1, the single clock; all state updates on the rising edge.
REQ-005 Port rst_in, input, 1, reset; asynchronous, active-low.
REQ-006 Port pc_mux_in, input, WIDTH, redirect / next-PC target.
REQ-007 Port pc_load_in, input, 1, load pc_mux_in instead of incrementing.
REQ-008 Port flush_in, input, 1, redirect to pc_mux_in and kill all tracked stages.
REQ-009 Port stall_in, input, 1, hold PC and all stages.
REQ-010 Port halt_in, input, 1, enter HALT.
REQ-011 Port resume_in, input, 1, leave HALT.
REQ-012 Port pc_out, output, WIDTH, current fetch PC.
REQ-013 Port pc_plus_4_out, output, WIDTH, combinational pc_out + 4, modulo 2^WIDTH.
REQ-014 Port stage_pc_out, output, DEPTH*WIDTH, tracked PCs; stage i occupies bits [i*WIDTH +: WIDTH].
REQ-015 Port stage_valid_out, output, DEPTH, valid bit per stage.
REQ-016 Port misaligned_out, output, 1, registered flag: the last loaded target had nonzero bits [1:0].
REQ-017 Port state_out, output, 2, FSM state: BOOT=0, RUN=1, HALT=2.

Function
REQ-018 The FSM SHALL have states BOOT, RUN and HALT; the encoding 3 SHALL be unreachable and SHALL recover to BOOT on the next edge.
REQ-019 BOOT SHALL last exactly one cycle and then go to RUN; during it pc_out holds BOOT_ADDRESS, and stage 0 captures BOOT_ADDRESS with valid=1 at the exit edge.
REQ-020 In RUN, per-cycle priority SHALL be: flush_in > halt_in > stall_in > pc_load_in > increment.
REQ-021 Flush SHALL do all of the following on the same edge: load pc_out with {pc_mux_in[WIDTH-1:2],2'b00}; clear all stage_valid_out bits; set misaligned_out to (pc_mux_in[1:0]!=0).
REQ-022 Halt (no flush) SHALL move RUN to HALT and hold pc_out; stage 0 receives a bubble (valid=0) and stages 1..DEPTH-1 keep shifting.
REQ-023 Stall (no flush or halt) SHALL hold pc_out, all stage PCs, all valids and misaligned_out unchanged.
REQ-024 Load SHALL set pc_out to {pc_mux_in[WIDTH-1:2],2'b00}, set misaligned_out to (pc_mux_in[1:0]!=0), and shift the stages.
REQ-025 Increment SHALL set pc_out to pc_out+4, wrapping modulo 2^WIDTH with no flag, clear misaligned_out, and shift the stages.
REQ-026 A shift SHALL move stage[i] to stage[i+1] (PC and valid) and load stage[0] with the old pc_out and valid=1; the oldest stage is discarded.
REQ-027 In HALT: resume_in moves to RUN on the next edge with no PC change that cycle; flush_in performs REQ-021 and stays in HALT unless resume_in is also 1; halt_in has no effect; stall_in is ignored.
REQ-028 In HALT the stages SHALL keep draining, inserting bubbles, until all valids are 0.
REQ-029 Simultaneous events in BOOT: flush_in performs REQ-021 and the FSM goes to RUN; all other inputs are ignored.
REQ-030 All outputs except pc_plus_4_out SHALL be registered.

Reset
REQ-031 Asserting rst_in low SHALL immediately, independent of clk_in, set pc_out=BOOT_ADDRESS, state=BOOT, all stage PCs=0, all valids=0 and misaligned_out=0.
REQ-032 Reset asserted mid-operation, including in HALT or during a stall, SHALL produce the REQ-031 values with no dependence on prior state.
REQ-033 After rst_in rises, the first rising edge SHALL be treated as the BOOT cycle edge.

Verification
REQ-034 Reset, then 4 free-running edges (DEPTH=3) -> pc_out 0x0, 0x4, 0x8, 0xC, 0x10; stage_valid_out 000, 001, 011, 111, 111; stage 2 = 0x4 at the last edge.
REQ-035 pc_load_in=1, pc_mux_in=0x12345678 in RUN -> pc_out=0x12345678 and misaligned_out=0 next cycle; pc_mux_in=0x12345679 -> pc_out=0x12345678 and misaligned_out=1.
REQ-036 flush_in and stall_in both 1 with pc_mux_in=0x80 -> pc_out=0x80 and stage_valid_out=000 on the next edge; stall_in alone for 3 cycles -> all outputs frozen.
REQ-037 pc_out=0xFFFFFFFC, increment -> pc_out=0x00000000 and pc_plus_4_out=0x4; halt_in for 1 cycle, then 4 idle cycles -> pc held, valids drain to 000, state_out=2; resume_in -> state_out=1 and increment resumes.
REQ-038 rst_in driven low between clock edges while in HALT with stall_in=1 -> outputs reach REQ-031 values before the next rising edge.
REQ-039 WIDTH=64, BOOT_ADDRESS=0x1000, DEPTH=1 -> after reset and 2 edges, pc_out=0x1008 and stage 0 = 0x1004, valid=1.

Source files
------------

// File: rtl/msrv32_pc_pipe_reg.sv
// Fetch PC register with BOOT/RUN/HALT control and a DEPTH-deep shift chain
// tracking the PCs of in-flight instructions.
module msrv32_pc_pipe_reg #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] BOOT_ADDRESS = '0,
    parameter int unsigned      DEPTH        = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [WIDTH-1:0]         pc_mux_in,
    input  logic                     pc_load_in,
    input  logic                     flush_in,
    input  logic                     stall_in,
    input  logic                     halt_in,
    input  logic                     resume_in,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         pc_plus_4_out,
    output logic [DEPTH*WIDTH-1:0]   stage_pc_out,
    output logic [DEPTH-1:0]         stage_valid_out,
    output logic                     misaligned_out,
    output logic [1:0]               state_out
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       pc_q, pc_d;
    logic                   mis_q, mis_d;
    logic [DEPTH*WIDTH-1:0] stage_pc_q, stage_pc_d;
    logic [DEPTH-1:0]       valid_q, valid_d;

    logic                   shift_en;
    logic                   flush_en;
    logic [WIDTH-1:0]       head_pc;
    logic                   head_valid;
    logic [WIDTH-1:0]       target;
    logic [WIDTH-1:0]       pc_inc;

    assign target = {pc_mux_in[WIDTH-1:2], 2'b00};
    assign pc_inc = pc_q + WIDTH'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mis_d      = mis_q;
        stage_pc_d = stage_pc_q;
        valid_d    = valid_q;
        shift_en   = 1'b0;
        flush_en   = 1'b0;
        head_pc    = pc_q;
        head_valid = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (flush_in) begin
                    flush_en = 1'b1;
                end else begin
                    pc_d       = BOOT_ADDRESS + WIDTH'(4);
                    mis_d      = 1'b0;
                    shift_en   = 1'b1;
                    head_pc    = BOOT_ADDRESS;
                    head_valid = 1'b1;
                end
            end
            RUN: begin
                if (flush_in) begin
                    flush_en = 1'b1;
                end else if (halt_in) begin
                    state_d  = HALT;
                    shift_en = 1'b1;
                end else if (stall_in) begin
                    state_d = RUN;
                end else if (pc_load_in) begin
                    pc_d       = target;
                    mis_d      = |pc_mux_in[1:0];
                    shift_en   = 1'b1;
                    head_valid = 1'b1;
                end else begin
                    pc_d       = pc_inc;
                    mis_d      = 1'b0;
                    shift_en   = 1'b1;
                    head_valid = 1'b1;
                end
            end
            HALT: begin
                if (resume_in) begin
                    state_d = RUN;
                end
                // Drain with bubbles only while something is still tracked.
                if (flush_in) begin
                    flush_en = 1'b1;
                end else if (|valid_q) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = BOOT_ADDRESS;
                mis_d   = 1'b0;
                valid_d = '0;
            end
        endcase

        if (shift_en) begin
            stage_pc_d = (stage_pc_q << WIDTH) | (DEPTH*WIDTH)'(head_pc);
            valid_d    = (valid_q << 1) | DEPTH'(head_valid);
        end

        if (flush_en) begin
            pc_d    = target;
            mis_d   = |pc_mux_in[1:0];
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= BOOT;
            pc_q       <= BOOT_ADDRESS;
            mis_q      <= 1'b0;
            stage_pc_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mis_q      <= mis_d;
            stage_pc_q <= stage_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_out          = pc_q;
    assign pc_plus_4_out   = pc_inc;
    assign stage_pc_out    = stage_pc_q;
    assign stage_valid_out = valid_q;
    assign misaligned_out  = mis_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_msrv32_pc_pipe_reg.sv
// Directed bench for msrv32_pc_pipe_reg: default 32-bit/DEPTH=3 instance plus
// a 64-bit DEPTH=1 instance with a nonzero boot address.
module tb_msrv32_pc_pipe_reg;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] pc_mux_in;
    logic        pc_load_in, flush_in, stall_in, halt_in, resume_in;
    logic [31:0] pc_out, pc_plus_4_out;
    logic [95:0] stage_pc_out;
    logic [2:0]  stage_valid_out;
    logic        misaligned_out;
    logic [1:0]  state_out;

    logic        rst_w;
    logic [63:0] pc_mux_w;
    logic [63:0] pc_w, pc_plus_4_w, stage_pc_w;
    logic [0:0]  stage_valid_w;
    logic        mis_w;
    logic [1:0]  state_w;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    msrv32_pc_pipe_reg #(.WIDTH(32), .BOOT_ADDRESS(32'h0), .DEPTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .pc_mux_in(pc_mux_in),
        .pc_load_in(pc_load_in), .flush_in(flush_in), .stall_in(stall_in),
        .halt_in(halt_in), .resume_in(resume_in), .pc_out(pc_out),
        .pc_plus_4_out(pc_plus_4_out), .stage_pc_out(stage_pc_out),
        .stage_valid_out(stage_valid_out), .misaligned_out(misaligned_out),
        .state_out(state_out)
    );

    msrv32_pc_pipe_reg #(.WIDTH(64), .BOOT_ADDRESS(64'h1000), .DEPTH(1)) dut_w (
        .clk_in(clk_in), .rst_in(rst_w), .pc_mux_in(pc_mux_w),
        .pc_load_in(1'b0), .flush_in(1'b0), .stall_in(1'b0),
        .halt_in(1'b0), .resume_in(1'b0), .pc_out(pc_w),
        .pc_plus_4_out(pc_plus_4_w), .stage_pc_out(stage_pc_w),
        .stage_valid_out(stage_valid_w), .misaligned_out(mis_w),
        .state_out(state_w)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; pc_mux_in = '0; pc_load_in = 0; flush_in = 0;
        stall_in = 0; halt_in = 0; resume_in = 0;
        #12;
        checks++;
        if (pc_out !== 32'h0 || state_out !== 2'd0 || stage_valid_out !== 3'b000 ||
            stage_pc_out !== 96'h0 || misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h st=%0d v=%b stg=%h mis=%b, need pc=0 st=0 v=000 stg=0 mis=0",
                     pc_out, state_out, stage_valid_out, stage_pc_out, misaligned_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_free_run();
        logic [2:0] exp_v [4] = '{3'b001, 3'b011, 3'b111, 3'b111};
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (pc_out !== 32'(4 * (k + 1)) || stage_valid_out !== exp_v[k] || state_out !== 2'd1) begin
                errors++;
                $display("FAIL free_run[%0d]: pc=%h v=%b st=%0d, need pc=%h v=%b st=1",
                         k, pc_out, stage_valid_out, state_out, 32'(4 * (k + 1)), exp_v[k]);
            end
        end
        checks++;
        if (stage_pc_out !== {32'h4, 32'h8, 32'hC} || pc_plus_4_out !== 32'h14) begin
            errors++;
            $display("FAIL free_run_stages: stg=%h p4=%h, need stg=%h p4=14",
                     stage_pc_out, pc_plus_4_out, {32'h4, 32'h8, 32'hC});
        end
    endtask

    task automatic test_load();
        pc_load_in = 1; pc_mux_in = 32'h12345678;
        step();
        checks++;
        if (pc_out !== 32'h12345678 || misaligned_out !== 1'b0 || stage_pc_out[31:0] !== 32'h10) begin
            errors++;
            $display("FAIL load_aligned: pc=%h mis=%b s0=%h, need 12345678 0 00000010",
                     pc_out, misaligned_out, stage_pc_out[31:0]);
        end
        pc_mux_in = 32'h12345679;
        step();
        checks++;
        if (pc_out !== 32'h12345678 || misaligned_out !== 1'b1 || stage_valid_out !== 3'b111) begin
            errors++;
            $display("FAIL load_misaligned: pc=%h mis=%b v=%b, need 12345678 1 111",
                     pc_out, misaligned_out, stage_valid_out);
        end
        pc_load_in = 0;
    endtask

    task automatic test_stall();
        stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (pc_out !== 32'h12345678 || misaligned_out !== 1'b1 || stage_valid_out !== 3'b111 ||
                stage_pc_out !== {32'hC, 32'h10, 32'h12345678} || state_out !== 2'd1) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h mis=%b v=%b stg=%h st=%0d, need frozen 12345678/1/111",
                         k, pc_out, misaligned_out, stage_valid_out, stage_pc_out, state_out);
            end
        end
        stall_in = 0;
        step();
        checks++;
        if (pc_out !== 32'h1234567C || misaligned_out !== 1'b0 ||
            stage_pc_out !== {32'h10, 32'h12345678, 32'h12345678}) begin
            errors++;
            $display("FAIL stall_release: pc=%h mis=%b stg=%h, need 1234567c 0 %h",
                     pc_out, misaligned_out, stage_pc_out, {32'h10, 32'h12345678, 32'h12345678});
        end
    endtask

    task automatic test_flush_stall();
        flush_in = 1; stall_in = 1; pc_mux_in = 32'h80;
        step();
        checks++;
        if (pc_out !== 32'h80 || stage_valid_out !== 3'b000 || misaligned_out !== 1'b0 || state_out !== 2'd1) begin
            errors++;
            $display("FAIL flush_stall: pc=%h v=%b mis=%b st=%0d, need 80 000 0 1",
                     pc_out, stage_valid_out, misaligned_out, state_out);
        end
        flush_in = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (pc_out !== 32'h80 || stage_valid_out !== 3'b000 || pc_plus_4_out !== 32'h84) begin
                errors++;
                $display("FAIL post_flush_stall[%0d]: pc=%h v=%b p4=%h, need 80 000 84",
                         k, pc_out, stage_valid_out, pc_plus_4_out);
            end
        end
        stall_in = 0; flush_in = 1; pc_mux_in = 32'h103;
        step();
        checks++;
        if (pc_out !== 32'h100 || misaligned_out !== 1'b1 || stage_valid_out !== 3'b000) begin
            errors++;
            $display("FAIL flush_misaligned: pc=%h mis=%b v=%b, need 100 1 000",
                     pc_out, misaligned_out, stage_valid_out);
        end
        flush_in = 0;
    endtask

    task automatic test_wrap_halt();
        logic [2:0] exp_v [4] = '{3'b100, 3'b000, 3'b000, 3'b000};
        pc_load_in = 1; pc_mux_in = 32'hFFFFFFFC;
        step();
        pc_load_in = 0;
        step();
        checks++;
        if (pc_out !== 32'h0 || pc_plus_4_out !== 32'h4 || stage_valid_out !== 3'b011 ||
            stage_pc_out[31:0] !== 32'hFFFFFFFC || misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap: pc=%h p4=%h v=%b s0=%h mis=%b, need 0 4 011 fffffffc 0",
                     pc_out, pc_plus_4_out, stage_valid_out, stage_pc_out[31:0], misaligned_out);
        end
        step();
        halt_in = 1;
        step();
        checks++;
        if (state_out !== 2'd2 || pc_out !== 32'h4 || stage_valid_out !== 3'b110) begin
            errors++;
            $display("FAIL halt_enter: st=%0d pc=%h v=%b, need 2 4 110", state_out, pc_out, stage_valid_out);
        end
        halt_in = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (state_out !== 2'd2 || pc_out !== 32'h4 || stage_valid_out !== exp_v[k]) begin
                errors++;
                $display("FAIL halt_drain[%0d]: st=%0d pc=%h v=%b, need 2 4 %b",
                         k, state_out, pc_out, stage_valid_out, exp_v[k]);
            end
        end
        resume_in = 1;
        step();
        checks++;
        if (state_out !== 2'd1 || pc_out !== 32'h4) begin
            errors++;
            $display("FAIL resume: st=%0d pc=%h, need 1 4", state_out, pc_out);
        end
        resume_in = 0;
        step();
        checks++;
        if (pc_out !== 32'h8 || stage_valid_out !== 3'b001 || stage_pc_out[31:0] !== 32'h4) begin
            errors++;
            $display("FAIL resume_inc: pc=%h v=%b s0=%h, need 8 001 4", pc_out, stage_valid_out, stage_pc_out[31:0]);
        end
        halt_in = 1;
        step();
        halt_in = 0; flush_in = 1; pc_mux_in = 32'h200;
        step();
        checks++;
        if (state_out !== 2'd2 || pc_out !== 32'h200 || stage_valid_out !== 3'b000) begin
            errors++;
            $display("FAIL halt_flush: st=%0d pc=%h v=%b, need 2 200 000", state_out, pc_out, stage_valid_out);
        end
        flush_in = 0; resume_in = 1;
        step();
        resume_in = 0;
        step();
        checks++;
        if (state_out !== 2'd1 || pc_out !== 32'h204) begin
            errors++;
            $display("FAIL halt_flush_resume: st=%0d pc=%h, need 1 204", state_out, pc_out);
        end
    endtask

    task automatic test_async_reset();
        halt_in = 1;
        step();
        halt_in = 0; stall_in = 1;
        step();
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h0 || state_out !== 2'd0 || stage_valid_out !== 3'b000 ||
            stage_pc_out !== 96'h0 || misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h st=%0d v=%b stg=%h mis=%b, need all zero",
                     pc_out, state_out, stage_valid_out, stage_pc_out, misaligned_out);
        end
        stall_in = 0;
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h4 || stage_valid_out !== 3'b001 || state_out !== 2'd1 || stage_pc_out[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_boot: pc=%h v=%b st=%0d s0=%h, need 4 001 1 0",
                     pc_out, stage_valid_out, state_out, stage_pc_out[31:0]);
        end
    endtask

    task automatic test_wide();
        @(negedge clk_in);
        checks++;
        if (pc_w !== 64'h1000 || state_w !== 2'd0 || stage_valid_w !== 1'b0) begin
            errors++;
            $display("FAIL wide_reset: pc=%h st=%0d v=%b, need 1000 0 0", pc_w, state_w, stage_valid_w);
        end
        rst_w = 1'b1;
        step();
        step();
        checks++;
        if (pc_w !== 64'h1008 || stage_pc_w !== 64'h1004 || stage_valid_w !== 1'b1 || pc_plus_4_w !== 64'h100C) begin
            errors++;
            $display("FAIL wide_run: pc=%h s0=%h v=%b p4=%h, need 1008 1004 1 100c",
                     pc_w, stage_pc_w, stage_valid_w, pc_plus_4_w);
        end
    endtask

    initial begin
        rst_w = 1'b0;
        pc_mux_w = '0;
        test_reset();
        test_free_run();
        test_load();
        test_stall();
        test_flush_stall();
        test_wrap_halt();
        test_async_reset();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
